// File: rtl/writeback_commit_if.sv
// Commit-stage bus: the instruction arriving from the memory stage, the
// interrupt inputs, and everything the commit stage sends to the regfile,
// CSR file, fetch and the hazard unit.
// master = upstream pipeline/environment side, slave = commit stage.
interface writeback_commit_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
);
  // Incoming instruction
  logic [XLEN-1:0]      pc_in;
  logic [XLEN-1:0]      next_pc_in;
  logic [XLEN-1:0]      alu_data_in;
  logic [XLEN-1:0]      csr_data_in;
  logic [XLEN-1:0]      load_data_in;
  logic [1:0]           write_select_in;
  logic [4:0]           rd_address_in;
  logic [11:0]          csr_address_in;
  logic                 csr_write_in;
  logic                 mret_in;
  logic                 wfi_in;
  logic                 valid_in;
  logic                 exception_in;
  logic [3:0]           ecause_in;
  // Interrupt lines
  logic                 sip;
  logic                 tip;
  logic                 eip;
  logic                 mie;
  // Commit results
  logic [4:0]           rd_address;
  logic [XLEN-1:0]      rd_data;
  logic                 csr_write;
  logic [11:0]          csr_address;
  logic [XLEN-1:0]      csr_data;
  logic                 traped;
  logic                 mret;
  logic [3:0]           ecause;
  logic                 interupt;
  logic [XLEN-1:0]      ecp;
  logic                 retired;
  logic                 stall;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    output pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in,
           write_select_in, rd_address_in, csr_address_in, csr_write_in,
           mret_in, wfi_in, valid_in, exception_in, ecause_in,
           sip, tip, eip, mie,
    input  rd_address, rd_data, csr_write, csr_address, csr_data,
           traped, mret, ecause, interupt, ecp, retired, stall, instret
  );

  modport slave (
    input  pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in,
           write_select_in, rd_address_in, csr_address_in, csr_write_in,
           mret_in, wfi_in, valid_in, exception_in, ecause_in,
           sip, tip, eip, mie,
    output rd_address, rd_data, csr_write, csr_address, csr_data,
           traped, mret, ecause, interupt, ecp, retired, stall, instret
  );
endinterface

// File: rtl/writeback_commit.sv
// Commit stage at the tail of the pipeline. Picks the write-back value,
// arbitrates interrupts against synchronous exceptions and registers every
// commit output. A WFI sleep state and a one-cycle post-trap flush state
// sequence the commit.
// Optional feature: define RETIRE_COUNTER_EN to build the retired-instruction
// counter (instret); otherwise instret is tied to zero.
module writeback_commit #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  writeback_commit_if.slave bus
);

  localparam logic [1:0] WRITE_SEL_ALU     = 2'd0;
  localparam logic [1:0] WRITE_SEL_CSR     = 2'd1;
  localparam logic [1:0] WRITE_SEL_LOAD    = 2'd2;
  localparam logic [1:0] WRITE_SEL_NEXT_PC = 2'd3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WFI_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t state, state_next;

  logic            irq_pending;
  logic            irq;
  logic [3:0]      trap_cause;
  logic [XLEN-1:0] saved_pc, saved_pc_next;

  logic [4:0]      rd_address_next;
  logic [XLEN-1:0] rd_data_next;
  logic            csr_write_next;
  logic [11:0]     csr_address_next;
  logic [XLEN-1:0] csr_data_next;
  logic            traped_next;
  logic            mret_next;
  logic [3:0]      ecause_next;
  logic            interupt_next;
  logic [XLEN-1:0] ecp_next;
  logic            retired_next;

  assign irq_pending = bus.sip | bus.tip | bus.eip;
  assign irq         = irq_pending & bus.mie;

  // Trap cause priority: external, timer, software, then the synchronous cause
  always_comb begin
    if (bus.eip)      trap_cause = 4'd11;
    else if (bus.tip) trap_cause = 4'd7;
    else if (bus.sip) trap_cause = 4'd3;
    else              trap_cause = bus.ecause_in;
  end

  // Next-state and commit decisions; a trap never commits rd, CSR or mret
  always_comb begin
    state_next       = state;
    saved_pc_next    = saved_pc;
    rd_address_next  = '0;
    rd_data_next     = '0;
    csr_write_next   = 1'b0;
    csr_address_next = '0;
    csr_data_next    = '0;
    traped_next      = 1'b0;
    mret_next        = 1'b0;
    ecause_next      = '0;
    interupt_next    = 1'b0;
    ecp_next         = '0;
    retired_next     = 1'b0;
    case (state)
      RUN: begin
        if (bus.valid_in) begin
          if (irq || bus.exception_in) begin
            traped_next   = 1'b1;
            ecause_next   = trap_cause;
            interupt_next = irq;
            ecp_next      = bus.pc_in;
            state_next    = FLUSH;
          end else begin
            retired_next    = 1'b1;
            rd_address_next = bus.rd_address_in;
            case (bus.write_select_in)
              WRITE_SEL_ALU:     rd_data_next = bus.alu_data_in;
              WRITE_SEL_CSR:     rd_data_next = bus.csr_data_in;
              WRITE_SEL_LOAD:    rd_data_next = bus.load_data_in;
              WRITE_SEL_NEXT_PC: rd_data_next = bus.next_pc_in;
              default:           rd_data_next = bus.alu_data_in;
            endcase
            csr_write_next = bus.csr_write_in;
            if (bus.csr_write_in) begin
              csr_address_next = bus.csr_address_in;
              csr_data_next    = bus.alu_data_in;
            end
            mret_next = bus.mret_in;
            if (bus.wfi_in) begin
              saved_pc_next = bus.next_pc_in;
              state_next    = WFI_WAIT;
            end
          end
        end
      end
      WFI_WAIT: begin
        if (irq_pending) begin
          if (bus.mie) begin
            traped_next   = 1'b1;
            ecause_next   = trap_cause;
            interupt_next = 1'b1;
            ecp_next      = saved_pc;
            state_next    = FLUSH;
          end else begin
            state_next = RUN;
          end
        end
      end
      FLUSH: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State register and saved WFI resume PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      saved_pc <= '0;
    end else begin
      state    <= state_next;
      saved_pc <= saved_pc_next;
    end
  end

  // Registered commit outputs; stall follows the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd_address  <= '0;
      bus.rd_data     <= '0;
      bus.csr_write   <= 1'b0;
      bus.csr_address <= '0;
      bus.csr_data    <= '0;
      bus.traped      <= 1'b0;
      bus.mret        <= 1'b0;
      bus.ecause      <= '0;
      bus.interupt    <= 1'b0;
      bus.ecp         <= '0;
      bus.retired     <= 1'b0;
      bus.stall       <= 1'b0;
    end else begin
      bus.rd_address  <= rd_address_next;
      bus.rd_data     <= rd_data_next;
      bus.csr_write   <= csr_write_next;
      bus.csr_address <= csr_address_next;
      bus.csr_data    <= csr_data_next;
      bus.traped      <= traped_next;
      bus.mret        <= mret_next;
      bus.ecause      <= ecause_next;
      bus.interupt    <= interupt_next;
      bus.ecp         <= ecp_next;
      bus.retired     <= retired_next;
      bus.stall       <= (state_next == WFI_WAIT);
    end
  end

`ifdef RETIRE_COUNTER_EN
  logic [CNT_WIDTH-1:0] instret_count;

  // Retired-instruction counter, moving in the same cycle as the retired pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_count <= '0;
    end else if (retired_next) begin
      instret_count <= instret_count + 1'b1;
    end
  end

  assign bus.instret = instret_count;
`else
  assign bus.instret = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/writeback_commit.md
# writeback_commit

Parametrised commit stage at the tail of the pipeline, after memory. Selects the register write-back value, arbitrates interrupts against synchronous exceptions, and registers all regfile and CSR commit outputs. A WFI sleep state machine and a post-trap flush state machine sequence the commit. Drives the regfile, the CSR file, fetch and the hazard unit, and optionally keeps the retired-instruction counter.

## Interface
- XLEN, 32, data/PC width
- CNT_WIDTH, 64, retired-instruction counter width (with RETIRE_COUNTER_EN)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pc_in, next_pc_in  in  XLEN  PC and next PC of the incoming instruction
- alu_data_in, csr_data_in, load_data_in  in  XLEN  write-back candidates
- write_select_in  in  2  WRITE_SEL_ALU/CSR/LOAD/NEXT_PC
- rd_address_in  in  5  destination register
- csr_address_in  in  12  CSR address; csr_write_in  in  1  CSR write request
- mret_in, wfi_in  in  1  instruction is MRET / WFI
- valid_in  in  1  incoming instruction valid
- exception_in  in  1  synchronous exception; ecause_in  in  4  its cause
- sip, tip, eip  in  1  software/timer/external interrupt pending (level)
- mie  in  1  global interrupt enable
- rd_address  out  5  regfile write address, 0 = no write
- rd_data  out  XLEN  regfile write data
- csr_write  out  1  CSR write strobe
- csr_address  out  12  CSR write address
- csr_data  out  XLEN  CSR write data
- traped, mret  out  1  one-cycle pulses to fetch, CSR and hazard
- ecause  out  4  trap cause
- interupt  out  1  trap is an interrupt
- ecp  out  XLEN  exception PC
- retired  out  1  one-cycle retire pulse
- stall  out  1  hold upstream (WFI sleep)
- instret  out  CNT_WIDTH  retired count (with RETIRE_COUNTER_EN)

## Operation
- States: RUN, WFI_WAIT, FLUSH. Reset state is RUN.
- irq = (sip|tip|eip)&mie.
- Priority: eip (cause 11), then tip (7), then sip (3), then exception_in (ecause_in, interupt=0).
- RUN, valid_in=1, irq or exception_in:
  - pulse traped with ecause/interupt.
  - ecp = pc_in.
  - no rd, CSR, mret or retired effect.
  - go to FLUSH.
- RUN, valid_in=1, no trap:
  - retire: rd_address = rd_address_in.
  - rd_data chosen by write_select_in.
  - csr_write = csr_write_in, with csr_address/csr_data = alu_data_in.
  - mret = mret_in; retired = 1.
  - if wfi_in, save next_pc_in, go to WFI_WAIT.
- RUN, valid_in=0: nothing committed. A pending irq waits for a valid instruction.
- WFI_WAIT:
  - stall=1; valid_in ignored.
  - on (sip|tip|eip) with mie=1: trap with ecp = saved next PC, go to FLUSH.
  - on (sip|tip|eip) with mie=0: go to RUN without a trap; stall drops.
- FLUSH: exactly one cycle. valid_in is discarded (the squashed instruction). Then RUN.
- A trap always suppresses mret, csr_write and the rd write in the same instruction.

## Timing
- All outputs are registered: commit effects appear one cycle after the accepting input cycle.
- Reset values: every output 0, rd_address 0, stall 0, instret 0.
- traped, mret, retired and csr_write are single-cycle pulses.
- stall asserts the cycle after the WFI retires. It deasserts the cycle after the wake condition.
- Wake to traped: 1 cycle.
- Reset mid-WFI or mid-FLUSH forces RUN asynchronously and clears the saved PC.

## Configuration
- RETIRE_COUNTER_EN defined:
  - instret increments on every retired pulse, including WFI.
  - instret wraps at 2^CNT_WIDTH to 0.
- RETIRE_COUNTER_EN undefined: instret is tied to 0 and no counter flops are built.

## Test plan
- alu_data_in=0x1234, write_select_in=ALU, rd_address_in=5, valid_in=1 -> next cycle rd_address=5, rd_data=0x1234, retired=1, instret=1.
- eip=1, tip=1, exception_in=1 (ecause_in=2), mie=1, pc_in=0x100 -> traped=1, ecause=11, interupt=1, ecp=0x100, rd_address=0, then one FLUSH cycle drops the next valid instruction.
- WFI, next_pc_in=0x204 -> stall=1. Raise tip with mie=1 -> traped, ecause=7, ecp=0x204.
- WFI, then sip with mie=0 -> stall drops, no traped, RUN resumes.
- mret_in=1 with csr_write_in=1 and exception_in=1 (ecause_in=4) -> traped=1, ecause=4, mret=0, csr_write=0.
- CNT_WIDTH=4, 16 retires -> instret wraps 15->0. Assert reset during WFI_WAIT -> stall=0, state RUN.
